// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - instruction fetch stage with PC sequencing for the single-cycle MIPS datapath
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               zero,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    output logic [COUNT_W-1:0] retired_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [5:0]  op;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        taken;
    logic        retire;

    assign pc_plus4      = pc_q + 32'd4;
    assign imem_addr     = pc_q;
    assign pc_out        = pc_q;
    assign imem_req      = req_q;
    assign instruction   = instr_q;
    assign instr_valid   = valid_q;
    assign retired_count = count_q;

    assign retire = valid_q & instr_ready;

    // Next PC is derived from the held instruction; redirect overrides everything.
    always_comb begin
        op            = instr_q[31:26];
        branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_target = pc_plus4 + branch_off;
        jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        taken         = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
        next_pc       = pc_plus4;
        if (redirect_valid) begin
            next_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if ((op == OP_J) || (op == OP_JAL)) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        count_d = count_q;
        case (state_q)
            BOOT: begin
                state_d = REQ;
                req_d   = 1'b1;
                valid_d = 1'b0;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    pc_d    = next_pc;
                    count_d = count_q + COUNT_W'(1);
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed and randomized self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        zero = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] retired_count;

    int npass = 0;
    int ntotal = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_count = 32'h0;
    int last_wait = 0;

    mips_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .zero(zero), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference next-PC computed straight from the ISA rules.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic z, input logic rv, input logic [31:0] rpc);
        logic [31:0] p4;
        int unsigned op;
        int imm;
        p4 = pc + 32'd4;
        op = word >> 26;
        imm = int'(word & 32'h0000_FFFF);
        if (imm >= 32768) imm = imm - 65536;
        if (rv) return rpc - (rpc % 4);
        if (op == 2 || op == 3) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        if ((op == 4 && z) || (op == 5 && !z)) return p4 + 32'(imm * 4);
        return p4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h0;
        m_count = 32'h0;
        check("reset_req", {31'h0, imem_req}, 32'h0);
        check("reset_valid", {31'h0, instr_valid}, 32'h0);
        check("reset_instr", instruction, 32'h0);
        check("reset_pc", pc_out, 32'h0);
        check("reset_count", retired_count, 32'h0);
    endtask

    // One full fetch/retire: wait for request, ack after ack_dly cycles, stall ready_dly cycles, retire.
    task automatic fetch(input string tag, input logic [31:0] word, input int ack_dly, input int ready_dly,
                         input logic z, input logic rv, input logic [31:0] rpc);
        int w;
        w = 0;
        while (!imem_req && w < 20) begin
            instr_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        last_wait = w;
        if (!imem_req) begin
            check({tag, "_req_timeout"}, 32'h0, 32'h1);
            return;
        end
        check({tag, "_addr"}, imem_addr, m_pc);
        for (int k = 0; k < ack_dly; k++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            instr_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_addr_stable"}, imem_addr, m_pc);
            check({tag, "_req_hold"}, {31'h0, imem_req}, 32'h1);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        instr_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        check({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
        check({tag, "_instr"}, instruction, word);
        check({tag, "_pc_out"}, pc_out, m_pc);
        check({tag, "_req_drop"}, {31'h0, imem_req}, 32'h0);
        for (int k = 0; k < ready_dly; k++) begin
            instr_ready = 1'b0;
            zero = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc = $urandom;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_instr_stable"}, instruction, word);
            check({tag, "_pc_stable"}, pc_out, m_pc);
            check({tag, "_count_stall"}, retired_count, m_count);
        end
        instr_ready = 1'b1;
        zero = z;
        redirect_valid = rv;
        redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        m_pc = ref_next(m_pc, word, z, rv, rpc);
        m_count = m_count + 32'd1;
        check({tag, "_count"}, retired_count, m_count);
        check({tag, "_valid_drop"}, {31'h0, instr_valid}, 32'h0);
        check({tag, "_next_req"}, {31'h0, imem_req}, 32'h1);
        check({tag, "_next_addr"}, imem_addr, m_pc);
    endtask

    initial begin
        logic [31:0] word;
        logic [5:0] ops [6];
        ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h03;
        ops[3] = 6'h04; ops[4] = 6'h05; ops[5] = 6'h08;

        do_reset();
        check("boot_no_req", {31'h0, imem_req}, 32'h0);
        fetch("seq0", 32'h2008_0005, 0, 0, 1'b0, 1'b0, 32'h0);
        check("first_req_latency", 32'(last_wait), 32'd1);
        check("seq0_pc", imem_addr, 32'h4);
        fetch("seq1", 32'h2009_0003, 0, 0, 1'b0, 1'b0, 32'h0);
        check("seq_count2", retired_count, 32'd2);

        fetch("beq_taken", 32'h1109_0002, 0, 0, 1'b1, 1'b0, 32'h0);
        check("beq_taken_addr", imem_addr, 32'h14);
        fetch("redir8", 32'h0000_0020, 0, 0, 1'b0, 1'b1, 32'h8);
        fetch("beq_nt", 32'h1109_0002, 0, 0, 1'b0, 1'b0, 32'h0);
        check("beq_nt_addr", imem_addr, 32'hC);
        fetch("nop_c", 32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'h0);
        fetch("bne_back", 32'h1509_FFFF, 0, 0, 1'b0, 1'b0, 32'h0);
        check("bne_back_addr", imem_addr, 32'h10);

        fetch("redir_j", 32'h0000_0020, 0, 0, 1'b0, 1'b1, 32'h0040_0000);
        fetch("jump", 32'h0800_0040, 0, 0, 1'b0, 1'b0, 32'h0);
        check("jump_addr", imem_addr, 32'h0000_0100);
        fetch("redir_jal", 32'h0000_0020, 0, 0, 1'b0, 1'b1, 32'h0040_0000);
        fetch("jal", 32'h0C00_0040, 0, 0, 1'b0, 1'b0, 32'h0);
        check("jal_addr", imem_addr, 32'h0000_0100);

        fetch("slow", 32'h0000_0020, 3, 4, 1'b0, 1'b0, 32'h0);
        fetch("redir_prio", 32'h1109_0002, 0, 0, 1'b1, 1'b1, 32'h0000_0203);
        check("redir_prio_addr", imem_addr, 32'h0000_0200);

        fetch("to_top", 32'h0000_0020, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("top_pc4", pc_plus4, 32'h0);
        fetch("wrap", 32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        for (int i = 0; i < 40; i++) begin
            word = $urandom;
            word[31:26] = ops[$urandom_range(0, 5)];
            fetch("rand", word, $urandom_range(0, 2), $urandom_range(0, 2),
                  1'($urandom), ($urandom_range(0, 7) == 0), $urandom);
        end

        // Reset arriving alongside an ack must discard the word.
        while (!imem_req) @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0;
        m_pc = 32'h0;
        m_count = 32'h0;
        check("midrst_valid", {31'h0, instr_valid}, 32'h0);
        check("midrst_pc", pc_out, 32'h0);
        check("midrst_count", retired_count, 32'h0);
        check("midrst_instr", instruction, 32'h0);
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        fetch("after_rst", 32'h2008_0005, 0, 0, 1'b0, 1'b0, 32'h0);
        check("after_rst_latency", 32'(last_wait), 32'd1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle MIPS datapath (monociclo_top).
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents each word to the datapath over a valid/ready handshake.
- Computes the next PC from the retiring instruction (beq/bne using the datapath's Zero, j/jal) or from an external redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address, equals pc while imem_req=1
imem_ack  in  1  memory accepts request; imem_rdata valid same cycle
imem_rdata  in  32  fetched instruction word
instruction  out  32  held instruction presented to datapath
instr_valid  out  1  instruction is valid
instr_ready  in  1  datapath retires the instruction this cycle
zero  in  1  ALU Zero flag for the presented instruction, sampled only on retire
redirect_valid  in  1  external redirect (jr, exception), sampled only on retire
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
pc_out  out  32  address of the presented instruction
pc_plus4  out  32  pc_out + 4, combinational
retired_count  out  COUNT_W  number of retired instructions, wraps

Behaviour:
- States: BOOT, REQ, HOLD.
- Reset (rst sampled high):
  - state=BOOT, pc=RESET_PC, imem_req=0, instr_valid=0, instruction=32'h0, retired_count=0.
  - Applies from any state. An outstanding request is abandoned; imem_ack in a reset cycle is ignored.
- BOOT: one cycle, then REQ. imem_req=0.
- REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack=1: instruction<=imem_rdata, instr_valid<=1, state<=HOLD, imem_req drops next cycle.
  - Without ack: stay in REQ, address stable.
- HOLD:
  - instr_valid=1; instruction and pc_out stable until retire.
  - Retire = instr_valid & instr_ready. On retire: pc<=next_pc, retired_count+=1, instr_valid<=0, state<=REQ.
  - Minimum cadence is 2 cycles per instruction (REQ with immediate ack, then HOLD with ready=1).
- next_pc priority, evaluated only on retire; op=instruction[31:26]:
  1. redirect_valid=1 -> {redirect_pc[31:2],2'b00}.
  2. op=6'b000010 (j) or 6'b000011 (jal) -> {pc_plus4[31:28], instruction[25:0], 2'b00}.
  3. op=6'b000100 (beq) and zero=1 -> taken.
  4. op=6'b000101 (bne) and zero=0 -> taken.
  5. Otherwise -> pc_plus4.
- Branch target (taken beq/bne) = pc_plus4 + (sign_extend(instruction[15:0]) << 2), modulo 2^32.
- Arithmetic: all PC sums are 32-bit modulo. pc=32'hFFFF_FFFC yields pc_plus4=0.
- zero and redirect_* are don't-care when not retiring. instr_ready while instr_valid=0 has no effect.
- Registered outputs: imem_req, instruction, instr_valid, retired_count, and pc (drives imem_addr/pc_out). pc_plus4 is combinational from pc.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: rst high 1 cycle; memory returns ack the same cycle as req with words 0x20080005, 0x20090003; ready=1.
  - Required: first req at cycle 2 with addr 0x0; instr_valid at cycle 3 with 0x20080005; second req addr 0x4; retired_count=2 after two retires.
- beq taken/not taken:
  - Stimulus: word 0x1109_0002 at pc 0x8.
  - Required: zero=1 at retire -> next req addr 0x14; zero=0 -> 0xC.
  - Also: bne 0x1509_FFFF at pc 0x10 with zero=0 -> next addr 0x10.
- Jump:
  - Stimulus: 0x0800_0040 at pc 0x0040_0000.
  - Required: next req addr 0x0000_0100. jal 0x0C00_0040 gives the same.
- Backpressure and slow memory:
  - Stimulus: ack delayed 3 cycles; ready low 4 cycles in HOLD.
  - Required: imem_addr stable throughout REQ; instruction/pc_out stable throughout HOLD; retired_count increments exactly once.
- Redirect priority:
  - Stimulus: redirect_valid=1, redirect_pc=0x0000_0203 retiring alongside a taken beq.
  - Required: next addr 0x0000_0200.
- Wrap and mid-operation reset:
  - Stimulus: redirect to 0xFFFF_FFFC, then retire a non-branch word.
  - Required: next addr 0x0.
  - Stimulus: assert rst while in REQ with ack high.
  - Required: word discarded; instr_valid=0, pc=RESET_PC, retired_count=0.
